alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 191 +++++++++++++++++++
 tb/tb_alu_mc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts
// and an iterative shift-add multiplier behind a start/busy/done handshake.
module alu_mc #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf
);

  localparam int SW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t state, nstate;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [W2-1:0]    m_q, m_d;
  logic [W2-1:0]    p_q, p_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             mul_q, mul_d;
  logic             shl_q, shl_d;
  logic [WIDTH-1:0] out_d;
  logic             carry_d, ovf_d;

  logic [WIDTH:0]   sum, dif;
  logic [SW-1:0]    s;
  logic [W2-1:0]    pn;
  logic [WIDTH-1:0] an;
  logic             abit;
  logic             fin;
  logic             to_exec;
  logic [WIDTH-1:0] res;
  logic             rc, ro;

  assign sum = {1'b0, accum} + {1'b0, data};
  assign dif = {1'b0, accum} - {1'b0, data};
  assign s   = data[SW-1:0];
  assign pn  = p_q + (b_q[0] ? m_q : {W2{1'b0}});
  assign an  = shl_q ? {a_q[WIDTH-2:0], 1'b0}
                     : {1'b0, a_q[WIDTH-1:1]};
  assign abit = shl_q ? a_q[WIDTH-1] : a_q[0];

  always_comb begin
    nstate  = state;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    mul_d   = mul_q;
    shl_d   = shl_q;
    out_d   = out;
    carry_d = carry;
    ovf_d   = ovf;
    fin     = 1'b0;
    to_exec = 1'b0;
    res     = accum;
    rc      = 1'b0;
    ro      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        nstate = IDLE;
        if (start) begin
          fin = 1'b1;
          case (opcode)
            4'b0001: begin
              res = sum[WIDTH-1:0];
              rc  = sum[WIDTH];
              ro  = (accum[WIDTH-1] == data[WIDTH-1]) &&
                    (sum[WIDTH-1] != accum[WIDTH-1]);
            end
            4'b0010: begin
              res = dif[WIDTH-1:0];
              rc  = dif[WIDTH];
              ro  = (accum[WIDTH-1] != data[WIDTH-1]) &&
                    (dif[WIDTH-1] != accum[WIDTH-1]);
            end
            4'b0011: res = accum & data;
            4'b0100: res = accum | data;
            4'b0101: res = accum ^ data;
            4'b0110: res = data;
            4'b0111, 4'b1000: begin
              // first shift step happens on the accept edge
              if (s != '0) begin
                shl_d = (opcode == 4'b0111);
                mul_d = 1'b0;
                res   = shl_d ? {accum[WIDTH-2:0], 1'b0}
                              : {1'b0, accum[WIDTH-1:1]};
                rc    = shl_d ? accum[WIDTH-1] : accum[0];
                a_d   = res;
                cnt_d = 6'(s) - 6'd1;
                if (s != SW'(1)) begin
                  fin     = 1'b0;
                  to_exec = 1'b1;
                end
              end
            end
            4'b1001: begin
              if (MUL_EN) begin
                fin     = 1'b0;
                to_exec = 1'b1;
                mul_d   = 1'b1;
                p_d     = data[0] ? {{WIDTH{1'b0}}, accum}
                                  : {W2{1'b0}};
                m_d     = {{(WIDTH-1){1'b0}}, accum, 1'b0};
                b_d     = {1'b0, data[WIDTH-1:1]};
                cnt_d   = 6'(WIDTH - 1);
              end
            end
            default: res = accum;
          endcase
          if (to_exec) nstate = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 6'd1;
        if (mul_q) begin
          p_d = pn;
          m_d = {m_q[W2-2:0], 1'b0};
          b_d = {1'b0, b_q[WIDTH-1:1]};
          res = pn[WIDTH-1:0];
          rc  = |pn[W2-1:WIDTH];
        end else begin
          a_d = an;
          res = an;
          rc  = abit;
        end
        fin = (cnt_q == 6'd1);
      end
      default: nstate = IDLE;
    endcase
    if (fin) begin
      nstate  = DONE;
      out_d   = res;
      carry_d = rc;
      ovf_d   = ro;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      mul_q <= 1'b0;
      shl_q <= 1'b0;
      out   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= nstate;
      a_q   <= a_d;
      b_q   <= b_d;
      m_q   <= m_d;
      p_q   <= p_d;
      cnt_q <= cnt_d;
      mul_q <= mul_d;
      shl_q <= shl_d;
      out   <= out_d;
      carry <= carry_d;
      ovf   <= ovf_d;
    end
  end

  assign busy = (state == EXEC);
  assign done = (state == DONE);
  assign zero = (out == '0);
  assign neg  = out[WIDTH-1];

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: hand-computed vectors, one
// instance with MUL enabled and one with MUL reserved.
module tb_alu_mc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [7:0] accum = 8'h00;
  logic [7:0] data = 8'h00;

  logic       busy, done, zero, carry, neg, ovf;
  logic [7:0] out;
  logic       busy2, done2, zero2, carry2, neg2, ovf2;
  logic [7:0] out2;

  int nchk = 0;
  int nfail = 0;
  bit seen;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .opcode(opcode), .accum(accum), .data(data),
    .busy(busy), .done(done), .out(out),
    .zero(zero), .carry(carry), .neg(neg), .ovf(ovf)
  );

  alu_mc #(.WIDTH(8), .MUL_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .opcode(opcode), .accum(accum), .data(data),
    .busy(busy2), .done(done2), .out(out2),
    .zero(zero2), .carry(carry2), .neg(neg2), .ovf(ovf2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [3:0] op,
                    input logic [7:0] a,
                    input logic [7:0] d);
    opcode = op;
    accum  = a;
    data   = d;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_carry", 32'(carry), 32'h0);
    chk("rst_neg", 32'(neg), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    tick();

    go(4'h1, 8'hF0, 8'h20);
    chk("add_done", 32'(done), 32'h1);
    chk("add_busy", 32'(busy), 32'h0);
    chk("add_out", 32'(out), 32'h10);
    chk("add_carry", 32'(carry), 32'h1);
    chk("add_ovf", 32'(ovf), 32'h0);
    chk("add_zero", 32'(zero), 32'h0);
    tick();
    chk("add_pulse", 32'(done), 32'h0);

    go(4'h2, 8'h80, 8'h01);
    chk("sub_done", 32'(done), 32'h1);
    chk("sub_out", 32'(out), 32'h7F);
    chk("sub_carry", 32'(carry), 32'h0);
    chk("sub_ovf", 32'(ovf), 32'h1);
    chk("sub_neg", 32'(neg), 32'h0);
    tick();

    go(4'h2, 8'h01, 8'h02);
    chk("sub_bor_out", 32'(out), 32'hFF);
    chk("sub_bor_c", 32'(carry), 32'h1);
    chk("sub_bor_neg", 32'(neg), 32'h1);
    tick();

    go(4'h5, 8'h5A, 8'h5A);
    chk("xor_out", 32'(out), 32'h00);
    chk("xor_zero", 32'(zero), 32'h1);
    chk("xor_carry", 32'(carry), 32'h0);
    tick();

    go(4'h9, 8'h13, 8'h0E);
    for (int k = 1; k <= 7; k++) begin
      chk("mul_busy", 32'(busy), 32'h1);
      chk("mul_nodone", 32'(done), 32'h0);
      accum = 8'hFF;
      data  = 8'hFF;
      if (k == 4) begin
        opcode = 4'h1;
        start  = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("mul_done", 32'(done), 32'h1);
    chk("mul_busy0", 32'(busy), 32'h0);
    chk("mul_out", 32'(out), 32'h0A);
    chk("mul_carry", 32'(carry), 32'h1);
    go(4'h1, 8'h01, 8'h02);
    chk("b2b_done", 32'(done), 32'h1);
    chk("b2b_out", 32'(out), 32'h03);
    tick();

    go(4'h7, 8'h81, 8'h03);
    chk("shl_busy1", 32'(busy), 32'h1);
    tick();
    chk("shl_busy2", 32'(busy), 32'h1);
    tick();
    chk("shl_done", 32'(done), 32'h1);
    chk("shl_out", 32'(out), 32'h08);
    chk("shl_carry", 32'(carry), 32'h0);
    tick();

    go(4'h8, 8'h81, 8'h01);
    chk("shr_done", 32'(done), 32'h1);
    chk("shr_out", 32'(out), 32'h40);
    chk("shr_carry", 32'(carry), 32'h1);
    tick();

    go(4'h7, 8'h81, 8'h00);
    chk("shl0_done", 32'(done), 32'h1);
    chk("shl0_out", 32'(out), 32'h81);
    chk("shl0_carry", 32'(carry), 32'h0);
    chk("shl0_neg", 32'(neg), 32'h1);
    tick();

    go(4'h1, 8'h7F, 8'h01);
    chk("addv_ovf", 32'(ovf), 32'h1);
    tick();
    go(4'hF, 8'h3C, 8'h55);
    chk("rsv_done", 32'(done), 32'h1);
    chk("rsv_out", 32'(out), 32'h3C);
    chk("rsv_carry", 32'(carry), 32'h0);
    chk("rsv_ovf", 32'(ovf), 32'h0);
    tick();

    go(4'h9, 8'h3C, 8'h55);
    chk("nomul_done", 32'(done2), 32'h1);
    chk("nomul_busy", 32'(busy2), 32'h0);
    chk("nomul_out", 32'(out2), 32'h3C);
    chk("nomul_carry", 32'(carry2), 32'h0);
    chk("nomul_ovf", 32'(ovf2), 32'h0);
    chk("mul_en_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 8; k++) tick();

    go(4'h9, 8'h13, 8'h0E);
    tick();
    tick();
    chk("abort_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy0", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_out", 32'(out), 32'h00);
    chk("abort_zero", 32'(zero), 32'h1);
    chk("abort_carry", 32'(carry), 32'h0);
    chk("abort_neg", 32'(neg), 32'h0);
    chk("abort_ovf", 32'(ovf), 32'h0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done || busy) seen = 1'b1;
      tick();
    end
    chk("abort_quiet", 32'(seen), 32'h0);
    go(4'h1, 8'h01, 8'h01);
    chk("post_done", 32'(done), 32'h1);
    chk("post_out", 32'(out), 32'h02);
    chk("post_carry", 32'(carry), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
